// File: rtl/ram_port_arbiter_if.sv
// Request/grant bus tying the CPU control path, the program loader and the
// single-port RAM to the RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_lock;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              ram_ce_n;
  logic              ram_we_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output ram_ce_n, ram_we_n, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  ram_ce_n, ram_we_n, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU and the program
// loader: one registered access per two cycles, loader starvation bounded.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LDR_MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  ram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ldr_gnt_q, ldr_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              pend_rd_q, pend_rd_d;
  logic              pend_ldr_q, pend_ldr_d;
  logic              own_ldr_q, own_ldr_d;
  logic              own_we_q, own_we_d;

  logic              both_req;
  logic              at_max;
  logic              cpu_win;
  logic              ldr_win;

  // Next-state, arbitration and read-return logic
  always_comb begin
    state_d      = state_q;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    ram_ce_n_d   = 1'b1;
    ram_we_n_d   = 1'b1;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    pend_rd_d    = 1'b0;
    pend_ldr_d   = pend_ldr_q;
    own_ldr_d    = own_ldr_q;
    own_we_d     = own_we_q;
    cpu_win      = 1'b0;
    ldr_win      = 1'b0;
    both_req     = bus.cpu_req & bus.ldr_req;
    at_max       = (wait_cnt_q == CNT_W'(LDR_MAX_WAIT));

    // RAM data is valid the cycle after the access; hand it to its owner
    if (pend_rd_q) begin
      if (pend_ldr_q) begin
        ldr_rvalid_d = 1'b1;
        ldr_rdata_d  = bus.ram_rdata;
      end else begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = bus.ram_rdata;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (both_req) begin
          if (bus.cpu_lock || !at_max) begin
            cpu_win    = 1'b1;
            wait_cnt_d = at_max ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
          end else begin
            ldr_win    = 1'b1;
            wait_cnt_d = '0;
          end
        end else if (bus.cpu_req) begin
          cpu_win = 1'b1;
        end else if (bus.ldr_req && !bus.cpu_lock) begin
          ldr_win    = 1'b1;
          wait_cnt_d = '0;
        end

        if (cpu_win) begin
          state_d     = ACC;
          cpu_gnt_d   = 1'b1;
          ram_ce_n_d  = 1'b0;
          ram_we_n_d  = ~bus.cpu_we;
          ram_addr_d  = bus.cpu_addr;
          ram_wdata_d = bus.cpu_wdata;
          own_ldr_d   = 1'b0;
          own_we_d    = bus.cpu_we;
        end else if (ldr_win) begin
          state_d     = ACC;
          ldr_gnt_d   = 1'b1;
          ram_ce_n_d  = 1'b0;
          ram_we_n_d  = ~bus.ldr_we;
          ram_addr_d  = bus.ldr_addr;
          ram_wdata_d = bus.ldr_wdata;
          own_ldr_d   = 1'b1;
          own_we_d    = bus.ldr_we;
        end
      end

      ACC: begin
        state_d    = IDLE;
        pend_rd_d  = ~own_we_q;
        pend_ldr_d = own_ldr_q;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      ram_ce_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      wait_cnt_q   <= '0;
      pend_rd_q    <= 1'b0;
      pend_ldr_q   <= 1'b0;
      own_ldr_q    <= 1'b0;
      own_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      ram_ce_n_q   <= ram_ce_n_d;
      ram_we_n_q   <= ram_we_n_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_ldr_q   <= pend_ldr_d;
      own_ldr_q    <= own_ldr_d;
      own_we_q     <= own_we_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.ldr_gnt    = ldr_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.ram_ce_n   = ram_ce_n_q;
  assign bus.ram_we_n   = ram_we_n_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_port_arbiter;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LDR_MAX_WAIT(MAXW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous 16x8 RAM with a backdoor port for preloading
  logic [DW-1:0] ram_mem [16];
  logic          bd_en   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_en) ram_mem[bd_addr] <= bd_data;
    else if (!bus.ram_ce_n) begin
      if (!bus.ram_we_n) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else               bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: edges are numbered, a decision blocks the next edge
  logic [DW-1:0] mmem [16];
  int            edge_no   = 0;
  int            last_dec  = -10;
  int            pend_edge = -1;
  bit            pend_ldr  = 1'b0;
  logic [DW-1:0] pend_val  = '0;
  int            m_cnt     = 0;
  int            streak    = 0;

  logic          e_cpu_gnt, e_ldr_gnt, e_cpu_rv, e_ldr_rv, e_ce_n, e_we_n;
  logic [DW-1:0] e_cpu_rd, e_ldr_rd, e_wdata;
  logic [AW-1:0] e_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int            who;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (bd_en) mmem[bd_addr] = bd_data;
    if (!rst_n) begin
      e_cpu_gnt = 0; e_ldr_gnt = 0; e_cpu_rv = 0; e_ldr_rv = 0;
      e_ce_n = 1; e_we_n = 1; e_addr = '0; e_wdata = '0;
      e_cpu_rd = '0; e_ldr_rd = '0;
      m_cnt = 0; pend_edge = -1; last_dec = -10; streak = 0;
    end else begin
      e_cpu_gnt = 0; e_ldr_gnt = 0; e_cpu_rv = 0; e_ldr_rv = 0;
      e_ce_n = 1; e_we_n = 1;
      if (pend_edge == edge_no) begin
        if (pend_ldr) begin e_ldr_rv = 1; e_ldr_rd = pend_val; end
        else          begin e_cpu_rv = 1; e_cpu_rd = pend_val; end
        pend_edge = -1;
      end
      if (edge_no != last_dec + 1) begin
        who = 0;
        if (bus.cpu_req && bus.ldr_req) begin
          if (bus.cpu_lock || m_cnt < int'(MAXW)) begin
            who = 1;
            if (m_cnt < int'(MAXW)) m_cnt++;
            if (!bus.cpu_lock) begin
              streak++;
              n_tests++;
              if (streak > int'(MAXW)) begin
                n_fail++;
                $display("FAIL ldr_wait: loader lost %0d unlocked decisions, limit %0d", streak, MAXW);
              end
            end
          end else begin
            who = 2;
          end
        end else if (bus.cpu_req) begin
          who = 1;
        end else if (bus.ldr_req && !bus.cpu_lock) begin
          who = 2;
        end
        if (who != 0) begin
          last_dec = edge_no;
          if (who == 1) begin
            we = bus.cpu_we; a = bus.cpu_addr; d = bus.cpu_wdata; e_cpu_gnt = 1;
          end else begin
            we = bus.ldr_we; a = bus.ldr_addr; d = bus.ldr_wdata; e_ldr_gnt = 1;
            m_cnt = 0; streak = 0;
          end
          e_ce_n = 0; e_we_n = !we; e_addr = a; e_wdata = d;
          if (we) mmem[a] = d;
          else begin
            pend_edge = edge_no + 2; pend_ldr = (who == 2); pend_val = mmem[a];
          end
        end
      end
    end
    edge_no++;
  endtask

  task automatic compare();
    chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(e_cpu_gnt));
    chk("ldr_gnt",    32'(bus.ldr_gnt),    32'(e_ldr_gnt));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cpu_rv));
    chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(e_ldr_rv));
    chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(e_cpu_rd));
    chk("ldr_rdata",  32'(bus.ldr_rdata),  32'(e_ldr_rd));
    chk("ram_ce_n",   32'(bus.ram_ce_n),   32'(e_ce_n));
    chk("ram_we_n",   32'(bus.ram_we_n),   32'(e_we_n));
    chk("ram_addr",   32'(bus.ram_addr),   32'(e_addr));
    chk("ram_wdata",  32'(bus.ram_wdata),  32'(e_wdata));
  endtask

  // One clock: model and DUT advance on the edge, outputs compared just after
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  byte order [$];
  int  n_cg, n_lg;

  initial begin
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0);
    bus.cpu_lock = 1'b0;
    rst_n = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bd_en = 1'b1; bd_addr = AW'(i); bd_data = DW'($urandom);
      tick();
    end
    bd_en = 1'b0;

    // Reset with both requests high
    set_cpu(1, 0, 4'h1, '0);
    set_ldr(1, 0, 4'h2, '0);
    do_reset(2);
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("rst_ldr_gnt", 32'(bus.ldr_gnt), 0);
    chk("rst_ce_n", 32'(bus.ram_ce_n), 1);
    chk("rst_we_n", 32'(bus.ram_we_n), 1);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_ldr_rdata", 32'(bus.ldr_rdata), 0);
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // CPU read of RAM[3]=A5
    bd_en = 1'b1; bd_addr = 4'h3; bd_data = 8'hA5;
    tick();
    bd_en = 1'b0;
    set_cpu(1, 0, 4'h3, '0);
    tick();
    chk("rd_gnt", 32'(bus.cpu_gnt), 1);
    chk("rd_ce_n", 32'(bus.ram_ce_n), 0);
    chk("rd_we_n", 32'(bus.ram_we_n), 1);
    chk("rd_addr", 32'(bus.ram_addr), 32'h3);
    set_cpu(0, 0, '0, '0);
    tick();
    chk("rd_early_rvalid", 32'(bus.cpu_rvalid), 0);
    tick();
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("rd_rdata", 32'(bus.cpu_rdata), 32'hA5);
    tick();
    chk("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 0);
    chk("rd_rdata_held", 32'(bus.cpu_rdata), 32'hA5);

    // Loader write 5C to F, then CPU reads it back
    set_ldr(1, 1, 4'hF, 8'h5C);
    tick();
    chk("wr_gnt", 32'(bus.ldr_gnt), 1);
    chk("wr_we_n", 32'(bus.ram_we_n), 0);
    chk("wr_wdata", 32'(bus.ram_wdata), 32'h5C);
    set_ldr(0, 0, '0, '0);
    tick();
    tick();
    chk("wr_no_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("wr_no_ldr_rvalid", 32'(bus.ldr_rvalid), 0);
    set_cpu(1, 0, 4'hF, '0);
    tick();
    set_cpu(0, 0, '0, '0);
    tick();
    tick();
    chk("rb_rdata", 32'(bus.cpu_rdata), 32'h5C);
    chk("rb_ldr_rdata", 32'(bus.ldr_rdata), 0);

    // Fairness: both requests held continuously
    do_reset(1);
    set_cpu(1, 0, 4'h4, '0);
    set_ldr(1, 0, 4'h5, '0);
    order.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.cpu_gnt) order.push_back(8'h43);
      else if (bus.ldr_gnt) order.push_back(8'h4C);
    end
    chk("fair_count", 32'(order.size()), 20);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("fair_order[%0d]", i), 32'(order[i]), (i % 5 == 4) ? 32'h4C : 32'h43);

    // Lock: 10 decisions all to CPU, then loader wins as soon as lock drops
    do_reset(1);
    bus.cpu_lock = 1'b1;
    n_cg = 0; n_lg = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cpu_gnt) n_cg++;
      if (bus.ldr_gnt) n_lg++;
    end
    chk("lock_cpu_grants", 32'(n_cg), 10);
    chk("lock_ldr_grants", 32'(n_lg), 0);
    chk("lock_model_cnt", 32'(m_cnt), 4);
    bus.cpu_lock = 1'b0;
    tick();
    chk("unlock_ldr_gnt", 32'(bus.ldr_gnt), 1);
    chk("unlock_cpu_gnt", 32'(bus.cpu_gnt), 0);
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0);
    repeat (3) tick();

    // Reset during the access cycle of a CPU read
    set_cpu(1, 0, 4'h3, '0);
    tick();
    chk("racc_gnt", 32'(bus.cpu_gnt), 1);
    set_cpu(0, 0, '0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("racc_ce_n", 32'(bus.ram_ce_n), 1);
    chk("racc_we_n", 32'(bus.ram_we_n), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("racc_no_rvalid", 32'(bus.cpu_rvalid), 0);
    end
    chk("racc_rdata", 32'(bus.cpu_rdata), 0);

    // Random traffic: requesters hold until granted, then drop or renew
    for (int c = 0; c < 3000; c++) begin
      if (bus.cpu_gnt || !bus.cpu_req) begin
        if ((bus.cpu_gnt && $urandom_range(1) == 1) || (!bus.cpu_gnt && $urandom_range(2) == 0))
          set_cpu(1, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
        else
          set_cpu(0, 0, '0, '0);
      end
      if (bus.ldr_gnt || !bus.ldr_req) begin
        if ((bus.ldr_gnt && $urandom_range(1) == 1) || (!bus.ldr_gnt && $urandom_range(2) == 0))
          set_ldr(1, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
        else
          set_ldr(0, 0, '0, '0);
      end
      if ($urandom_range(7) == 0) bus.cpu_lock = ~bus.cpu_lock;
      rst_n = ($urandom_range(399) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port program/data RAM between the CPU control path and an external program loader. Each side uses a request/grant handshake. The block issues one registered RAM access at a time, returns read data to the owner, and bounds loader starvation with a wait counter. It sits between the control block / MAR and the 16x8 RAM, and drives the RAM's active-low enables.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
LDR_MAX_WAIT, 4, number of lost arbitrations after which the loader wins (range 1..15)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cpu_req  input  1  CPU access request; held with stable we/addr/wdata until cpu_gnt
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_lock  input  1  while high, loader is never granted (multi-cycle CPU sequences)
cpu_gnt  output  1  one-cycle pulse: CPU access issued this cycle
cpu_rvalid  output  1  one-cycle pulse: cpu_rdata updated
cpu_rdata  output  DATA_W  last CPU read data, held
ldr_req  input  1  loader request, same rules as cpu_req
ldr_we  input  1  1 = write, 0 = read
ldr_addr  input  ADDR_W  loader address
ldr_wdata  input  DATA_W  loader write data
ldr_gnt  output  1  one-cycle pulse: loader access issued this cycle
ldr_rvalid  output  1  one-cycle pulse: ldr_rdata updated
ldr_rdata  output  DATA_W  last loader read data, held
ram_ce_n  output  1  RAM chip enable, active low
ram_we_n  output  1  RAM write enable, active low
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  synchronous RAM read data, valid the cycle after the access cycle

Behaviour:
- Reset (rst_n low at posedge clk) clears: state=IDLE, all gnt/rvalid=0, rdata regs=0, ram_ce_n=1, ram_we_n=1, ram_addr=0, ram_wdata=0, wait counter=0, pending-read flag=0.
- All outputs are registered.
- FSM has two states, IDLE and ACC. Requests are sampled only in IDLE. ACC lasts exactly 1 cycle and always returns to IDLE. Peak throughput is one access per 2 cycles.
- Decision edge E0 (in IDLE, any req high):
  - Latch winner's we/addr/wdata onto ram_*.
  - Next cycle (ACC): ram_ce_n=0, ram_we_n=~we, winner's gnt=1.
  - Edge E1: ram_ce_n/ram_we_n return to 1 and gnt returns to 0. ram_addr/ram_wdata keep their values.
- The requester must drop req (or present a new request) by E1. A req still high in the IDLE cycle after ACC is treated as a new request.
- Reads: ram_rdata is valid in the cycle after ACC. At E2, ram_rdata is loaded into the owner's rdata register and the owner's rvalid pulses for 1 cycle. Request-to-rvalid latency is 3 edges. Writes produce no rvalid. The other port's rdata is unchanged.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting, cpu_lock=1: CPU wins, and the counter increments (saturating at LDR_MAX_WAIT).
  - Both requesting, cpu_lock=0, counter < LDR_MAX_WAIT: CPU wins, counter increments.
  - Both requesting, cpu_lock=0, counter == LDR_MAX_WAIT: loader wins, counter clears.
  - Loader requesting alone with cpu_lock=1: no grant; counter unchanged.
  - Any loader grant clears the counter.
  - Lock only gates new decisions. It never aborts an access already in ACC.
- Reset mid-operation: reset in ACC forces ram_ce_n/ram_we_n high at the next edge. The pending read is dropped, and no rvalid is ever produced for it.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with reqs high -> all gnt/rvalid 0, ram_ce_n=1, ram_we_n=1, rdata regs 0x00; no grant issued during reset.
- CPU read: RAM[0x3]=0xA5, cpu_req/we=0/addr=0x3 -> ACC cycle shows cpu_gnt=1, ram_ce_n=0, ram_we_n=1, ram_addr=0x3; cpu_rvalid pulses 2 cycles later with cpu_rdata=0xA5, held afterward.
- Loader write then CPU read: ldr write 0x5C to 0xF -> ACC shows ram_we_n=0, ram_wdata=0x5C, no rvalid on either port; following CPU read of 0xF -> cpu_rdata=0x5C, ldr_rdata unchanged.
- Fairness (LDR_MAX_WAIT=4): both req held continuously, requesters re-raise after each gnt -> grant order CPU,CPU,CPU,CPU,LDR, repeating; no loader wait exceeds 4 decisions.
- Lock: cpu_lock=1, both requesting for 10 decisions -> 10 CPU grants, 0 loader grants, counter saturated at 4; drop lock -> very next decision grants loader.
- Reset in ACC of a CPU read -> ram_ce_n=1 next cycle, cpu_rvalid never pulses, cpu_rdata=0x00.
